// File: rtl/div_iter32_if.sv
// Divide handshake between the EX stage (master) and the iterative divider (slave).
// Groups the request operands, the start/annul controls and the registered result.
interface div_iter32_if;
    logic        signed_div_i;  // 1 = signed DIV, 0 = unsigned DIVU
    logic [31:0] opdata1_i;     // dividend
    logic [31:0] opdata2_i;     // divisor
    logic        start_i;       // request, held until ready_o is seen
    logic        annul_i;       // abort the in-flight divide
    logic [63:0] result_o;      // {remainder, quotient}
    logic        ready_o;       // result valid

    // EX side: drives the request, consumes the result.
    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    // Divider side: consumes the request, produces the result.
    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_iter32.sv
// Iterative 32-bit integer divider for the EX-stage DIV/DIVU path.
// Restoring shift-subtract, one quotient bit per cycle, 32 iterations.
// result_o = {remainder, quotient}; quotient truncates toward zero and the
// remainder takes the dividend's sign in signed mode.
// Optional feature: define DIV_FAST_SMALL_EN to finish in one cycle when
// |dividend| < |divisor| (result is quotient 0, remainder = raw dividend).
module div_iter32 (
    input  logic         clk,
    input  logic         rst,
    div_iter32_if.slave  div_if
);

    typedef enum logic [1:0] {
        FREE,    // idle, waiting for an accepted request
        BYZERO,  // one-cycle short path (zero divisor, or small dividend)
        ON,      // shift-subtract iterations
        END      // result presented until start_i drops
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;
`ifdef DIV_FAST_SMALL_EN
    logic        small_q, small_d;
`endif

    // Operand magnitudes, evaluated only at accept time.
    logic        accept;
    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b;

    assign accept = div_if.start_i && !div_if.annul_i;
    assign a_neg  = div_if.signed_div_i && div_if.opdata1_i[31];
    assign b_neg  = div_if.signed_div_i && div_if.opdata2_i[31];
    assign abs_a  = a_neg ? (~div_if.opdata1_i + 32'd1) : div_if.opdata1_i;
    assign abs_b  = b_neg ? (~div_if.opdata2_i + 32'd1) : div_if.opdata2_i;

    // One restoring step: trial-subtract the divisor from the partial
    // remainder extended by the next dividend bit.
    logic [32:0] diff;
    logic [64:0] work_step;
    logic [31:0] quot_raw, rem_raw;
    logic [31:0] quot_fix, rem_fix;

    assign diff      = work_q[63:31] - {1'b0, divisor_q};
    assign work_step = diff[32] ? (work_q << 1)
                                : {1'b0, diff[31:0], work_q[30:0], 1'b1};
    assign quot_raw  = work_step[31:0];
    assign rem_raw   = work_step[63:32];
    assign quot_fix  = neg_quot_q ? (~quot_raw + 32'd1) : quot_raw;
    assign rem_fix   = neg_rem_q  ? (~rem_raw  + 32'd1) : rem_raw;

    // Next-state, datapath and output decode for the divider FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
`ifdef DIV_FAST_SMALL_EN
        small_d    = small_q;
`endif

        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = 64'd0;
                if (accept) begin
                    neg_quot_d = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    divisor_d  = abs_b;
`ifdef DIV_FAST_SMALL_EN
                    small_d    = 1'b0;
`endif
                    if (div_if.opdata2_i == 32'd0) begin
                        state_d = BYZERO;
                    end
`ifdef DIV_FAST_SMALL_EN
                    else if (abs_a < abs_b) begin
                        // Quotient is 0; the raw dividend is the remainder
                        // and is parked in the work register for one cycle.
                        small_d = 1'b1;
                        work_d  = {33'd0, div_if.opdata1_i};
                        state_d = BYZERO;
                    end
`endif
                    else begin
                        cnt_d   = 6'd0;
                        work_d  = {33'd0, abs_a};
                        state_d = ON;
                    end
                end
            end

            BYZERO: begin
                if (div_if.annul_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end else begin
                    state_d  = END;
                    ready_d  = 1'b1;
`ifdef DIV_FAST_SMALL_EN
                    result_d = small_q ? {work_q[31:0], 32'd0} : 64'd0;
`else
                    result_d = 64'd0;
`endif
                end
            end

            ON: begin
                if (div_if.annul_i) begin
                    // Annul wins even on the final iteration.
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end else begin
                    work_d = work_step;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = END;
                        ready_d  = 1'b1;
                        result_d = {rem_fix, quot_fix};
                    end
                end
            end

            END: begin
                ready_d = 1'b1;
                if (!div_if.start_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            end

            default: begin
                state_d  = FREE;
                ready_d  = 1'b0;
                result_d = 64'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from their pre-edge values.
        if (rst) begin
            // NOTE: the work register and operand state are reset too, so a
            // reset mid-divide leaves no stale partial result behind.
            state_q    <= FREE;
            cnt_q      <= 6'd0;
            work_q     <= 65'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
`ifdef DIV_FAST_SMALL_EN
            small_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
`ifdef DIV_FAST_SMALL_EN
            small_q    <= small_d;
`endif
        end
    end

    assign div_if.result_o = result_q;
    assign div_if.ready_o  = ready_q;

endmodule

// File: doc/div_iter32.md
# div_iter32

Iterative 32-bit integer divider for the EX stage's DIV/DIVU path. It is the responder side of the EX divide handshake: EX raises `start_i` with operands, holds the pipeline stalled, and consumes `result_o` when `ready_o` rises. It uses restoring shift-subtract, one quotient bit per cycle, and supports both signed (MIPS DIV) and unsigned (DIVU) division.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept
- `opdata1_i`  in  32  dividend; sampled at accept
- `opdata2_i`  in  32  divisor; sampled at accept
- `start_i`  in  1  request; held high by EX until it sees `ready_o`
- `annul_i`  in  1  abort the in-flight divide
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}, registered
- `ready_o`  out  1  result valid, registered

## Operation
- **States:** FREE, BYZERO, ON, END.
- **FREE**
  - Accept occurs when `start_i`=1 and `annul_i`=0.
  - On accept, capture the sign flags and the operand magnitudes. In signed mode, negative operands are two's-complement negated; in unsigned mode, operands are used raw.
  - If the divisor is 0, go to BYZERO. Otherwise clear the 6-bit counter, load the 65-bit work register {33'b0, |dividend|}, and go to ON.
- **ON**, per cycle:
  - Compute `diff` = work[63:31] − {1'b0, |divisor|}, 33 bits wide.
  - If `diff` is negative, work = work << 1 with LSB 0.
  - Otherwise, work = {diff[31:0], work[30:0], 1'b1}.
  - Increment the counter. After the 32nd iteration (counter = 31 → 32), go to END and register the result.
- **Result fix-up**, applied when entering END:
  - Quotient is negated if the signs differ (signed mode only).
  - Remainder is negated if the dividend was negative (signed mode only).
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0 (wraps, no trap).
- **BYZERO:** next cycle go to END with `result_o` = 0.
- **END**
  - `ready_o`=1 and `result_o` is valid.
  - If `start_i`=0, go to FREE next edge, clearing `ready_o` and `result_o` to 0.
  - If `start_i`=1, stay in END with the result held.
- **annul_i**
  - In ON or BYZERO: go to FREE next edge; `ready_o` stays 0 and `result_o` = 0.
  - In FREE: blocks accept.
  - In END: ignored.
- Operand or `signed_div_i` changes after accept are ignored until the next accept.

## Timing
- **Reset:** state FREE, `ready_o`=0, `result_o`=0, counter 0, work register 0. `rst` at any edge, including mid-ON or in END, forces this state at that edge; no partial result is ever presented.
- **Latency** (E0 = the edge that accepts the request):
  - Normal divide: ON iterations occur at edges E1..E32. `ready_o` and `result_o` become visible after E32 (33 edges including accept).
  - Divide by zero: BYZERO at E0, END at E1, so `ready_o`=1 after E1.
- **`ready_o` duration:** it is high for every cycle in END, and at least one cycle. EX drops `start_i` combinationally when it sees `ready_o`, so `ready_o` normally lasts exactly one cycle.
- **Back-to-back requests:** a new accept is possible on the edge after END→FREE, so there is one idle FREE cycle between requests.
- **Simultaneous events:**
  - `annul_i` with the final iteration (counter 31) in ON: annul wins and the result is discarded.
  - `rst` with `annul_i`: reset wins.

## Configuration
- Macro: `DIV_FAST_SMALL_EN`.
- **Defined:** at accept, if the divisor is nonzero and |dividend| < |divisor| (unsigned compare of magnitudes), skip ON and go directly to END at E1. The result is quotient 0 and remainder = the original `opdata1_i`, which keeps its sign.
- **Undefined:** all nonzero-divisor requests take the full 32-iteration ON path. Results are bit-identical either way; only latency differs.

## Test plan
- Unsigned 100 / 7 → `result_o` = {0x00000002, 0x0000000E}; `ready_o` rises after E32 and falls the cycle after `start_i` drops.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001. Unsigned 0xFFFFFFF9 / 2 → quotient 0x7FFFFFFC, remainder 1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, latency 33 edges.
- Divisor 0, any dividend (e.g. 5 / 0) → `result_o` = 0 with `ready_o` after E1. A following 9 / 3 request accepted one idle cycle later → quotient 3, remainder 0.
- Annul: assert `annul_i` at E10 → `ready_o` never rises and the state returns to FREE. A new request 50 / 5 issued afterwards completes correctly (quotient 10, remainder 0). Separately, assert `rst` mid-ON → outputs are 0 and the state is FREE.
- Small-dividend case 3 / 10 → remainder 3, quotient 0; `ready_o` after E1 with `DIV_FAST_SMALL_EN`, after E32 without. Signed −3 / 10 → remainder 0xFFFFFFFD, quotient 0 in both builds.
